st2bus_pack: RTL and testbench

ST2BUS_PACK -- requirements
Module: st2bus_pack

---
 rtl/st2bus_pack.sv | 238 +++++++++++++++++++++++
 tb/tb_st2bus_pack.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/st2bus_pack.sv
// st2bus_pack: packs a byte stream into wide bus words.
// Each word carries a 64-byte little-endian payload plus a byte count,
// first/last/err flags and a 12-bit packet sequence number.
module st2bus_pack #(
  parameter int BUS = 534,
  parameter int ST  = 8
) (
  input  logic           clk_st,
  input  logic           rst_n,
  input  logic [ST-1:0]  st_data,
  input  logic           st_valid,
  input  logic           st_sop,
  input  logic           st_eop,
  output logic           st_ready,
  output logic [BUS-1:0] bus_data,
  output logic           bus_en,
  input  logic           bus_ready
);

  localparam int LANES = 64;
  localparam int PW    = LANES * ST;

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t state, state_next;

  logic [LANES-1:0][ST-1:0] acc;
  logic [5:0]               idx;
  logic                     first_pend;
  logic                     err_drop;
  logic [ST-1:0]            pend_data;
  logic                     pend_valid;
  logic                     pend_eop;
  logic [5:0]               hold_cnt;
  logic                     hold_first;
  logic                     hold_last;
  logic                     hold_err;
  logic [11:0]              seq;
  logic [BUS-1:0]           out_data;
  logic                     out_valid;
  logic                     run;

  logic beat, in_fill, out_free;
  logic start, restart, fill_wr, drop, close_now, hold_go, load_out;
  logic [5:0]               cl_lane, cl_cnt;
  logic                     cl_incl, cl_first, cl_last, cl_err;
  logic [LANES-1:0][ST-1:0] cl_pay;
  logic [BUS-1:0]           load_word;

  // Builds one bus word from a payload and its descriptor fields.
  function automatic logic [BUS-1:0] pack_word(input logic [PW-1:0] pay,
                                               input logic [5:0] cnt,
                                               input logic f, input logic l,
                                               input logic e,
                                               input logic [11:0] sq);
    logic [BUS-1:0] w;
    w = '0;
    w[PW-1:0]     = pay;
    w[PW+5:PW]    = cnt;
    w[PW+6]       = f;
    w[PW+7]       = l;
    w[PW+8]       = e;
    w[PW+20:PW+9] = sq;
    return w;
  endfunction

  // run holds st_ready low until the first edge after reset release.
  assign st_ready = run & (state != HOLD);
  assign bus_en   = out_valid & bus_ready;
  assign bus_data = out_data;
  assign beat     = st_valid & st_ready;
  assign in_fill  = (state == FILL);
  assign out_free = ~out_valid | bus_en;

  // A sop at index 0 (IDLE, or FILL right after a full word) starts a word
  // directly; a sop with bytes already accumulated forces a restart close.
  assign start     = beat & st_sop & ((state == IDLE) | (in_fill & (idx == 6'd0)));
  assign restart   = beat & st_sop & in_fill & (idx != 6'd0);
  assign fill_wr   = beat & ~st_sop & in_fill;
  assign drop      = beat & ~st_sop & (state == IDLE);
  assign close_now = (start & st_eop) | restart | (fill_wr & (st_eop | (idx == 6'd63)));
  assign hold_go   = (state == HOLD) & out_free;
  assign load_out  = (close_now & out_free) | hold_go;

  // Describes the word that closes on this beat and the word to load.
  always_comb begin
    cl_lane  = start ? 6'd0 : idx;
    cl_incl  = ~restart;
    cl_cnt   = restart ? (idx - 6'd1) : (start ? 6'd0 : idx);
    cl_first = start | first_pend;
    cl_last  = start | restart | st_eop;
    cl_err   = restart | err_drop | (start & in_fill);
    for (int k = 0; k < LANES; k++) begin
      cl_pay[k] = (cl_incl && (cl_lane == 6'(k))) ? st_data : acc[k];
    end
    if (hold_go) begin
      load_word = pack_word(acc, hold_cnt, hold_first, hold_last, hold_err, seq);
    end else begin
      load_word = pack_word(cl_pay, cl_cnt, cl_first, cl_last, cl_err, seq);
    end
  end

  // Next-state decode for the IDLE/FILL/HOLD controller.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, FILL: begin
        if (restart) begin
          state_next = (out_free && !st_eop) ? FILL : HOLD;
        end else if (close_now) begin
          if (!out_free) begin
            state_next = HOLD;
          end else begin
            state_next = st_eop ? IDLE : FILL;
          end
        end else if (start) begin
          state_next = FILL;
        end
      end
      HOLD: begin
        if (out_free) begin
          if (pend_valid) begin
            state_next = pend_eop ? HOLD : FILL;
          end else begin
            state_next = hold_last ? IDLE : FILL;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_st or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Output register: loads a closed or held word, clears when it drains.
  always_ff @(posedge clk_st or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      seq       <= 12'd0;
    end else if (load_out) begin
      out_data  <= load_word;
      out_valid <= 1'b1;
      if (hold_go ? hold_last : cl_last) begin
        seq <= seq + 12'd1;
      end
    end else if (bus_en) begin
      out_valid <= 1'b0;
    end
  end

  // Accumulator, byte index, pending byte and held-word descriptor.
  always_ff @(posedge clk_st or negedge rst_n) begin
    if (!rst_n) begin
      run        <= 1'b0;
      acc        <= '0;
      idx        <= 6'd0;
      first_pend <= 1'b0;
      err_drop   <= 1'b0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      pend_eop   <= 1'b0;
      hold_cnt   <= 6'd0;
      hold_first <= 1'b0;
      hold_last  <= 1'b0;
      hold_err   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (hold_go) begin
        acc <= '0;
        idx <= 6'd0;
        if (pend_valid) begin
          acc[0]     <= pend_data;
          pend_valid <= 1'b0;
          if (pend_eop) begin
            hold_cnt   <= 6'd0;
            hold_first <= 1'b1;
            hold_last  <= 1'b1;
            hold_err   <= 1'b0;
          end else begin
            idx        <= 6'd1;
            first_pend <= 1'b1;
          end
        end
      end else if (close_now) begin
        first_pend <= 1'b0;
        err_drop   <= 1'b0;
        idx        <= 6'd0;
        if (out_free) begin
          acc <= '0;
          if (restart) begin
            acc[0] <= st_data;
            if (st_eop) begin
              hold_cnt   <= 6'd0;
              hold_first <= 1'b1;
              hold_last  <= 1'b1;
              hold_err   <= 1'b0;
            end else begin
              idx        <= 6'd1;
              first_pend <= 1'b1;
            end
          end
        end else begin
          acc        <= cl_pay;
          hold_cnt   <= cl_cnt;
          hold_first <= cl_first;
          hold_last  <= cl_last;
          hold_err   <= cl_err;
          if (restart) begin
            pend_data  <= st_data;
            pend_valid <= 1'b1;
            pend_eop   <= st_eop;
          end
        end
      end else if (start) begin
        acc[0]     <= st_data;
        idx        <= 6'd1;
        first_pend <= 1'b1;
        if (in_fill) begin
          err_drop <= 1'b1;
        end
      end else if (fill_wr) begin
        acc[idx] <= st_data;
        idx      <= idx + 6'd1;
      end else if (drop) begin
        err_drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_st2bus_pack.sv
// tb_st2bus_pack: directed stimulus with a scoreboard queue of expected
// bus words; a monitor pops and compares every word the DUT strobes out.
module tb_st2bus_pack;

  localparam int BUS = 534;
  localparam int ST  = 8;

  logic           clk_st = 1'b0;
  logic           rst_n;
  logic [ST-1:0]  st_data;
  logic           st_valid, st_sop, st_eop;
  logic           st_ready;
  logic [BUS-1:0] bus_data;
  logic           bus_en;
  logic           bus_ready;

  logic [BUS-1:0] exp_q[$];
  int total  = 0;
  int bad    = 0;
  int popped = 0;

  st2bus_pack #(.BUS(BUS), .ST(ST)) dut (
    .clk_st   (clk_st),
    .rst_n    (rst_n),
    .st_data  (st_data),
    .st_valid (st_valid),
    .st_sop   (st_sop),
    .st_eop   (st_eop),
    .st_ready (st_ready),
    .bus_data (bus_data),
    .bus_en   (bus_en),
    .bus_ready(bus_ready)
  );

  // 10 ns clock.
  always #5 clk_st = ~clk_st;

  task automatic checkOutput(input string name, input logic [BUS-1:0] act,
                             input logic [BUS-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Expected word: lanes 0..cnt hold base, base+1, ...; other lanes zero.
  task automatic pushExp(input logic [7:0] base, input int cnt, input bit f,
                         input bit l, input bit e, input logic [11:0] sq);
    logic [BUS-1:0] w;
    w = '0;
    for (int k = 0; k <= cnt; k++) w[8*k +: 8] = base + 8'(k);
    w[517:512] = 6'(cnt);
    w[518]     = f;
    w[519]     = l;
    w[520]     = e;
    w[532:521] = sq;
    exp_q.push_back(w);
  endtask

  // One beat, entered and left on a falling edge.
  task automatic applyStimulus(input logic [7:0] d, input bit s, input bit e);
    int n;
    st_data  = d;
    st_sop   = s;
    st_eop   = e;
    st_valid = 1'b1;
    n = 0;
    while (st_ready !== 1'b1 && n < 1000) begin
      @(negedge clk_st);
      n++;
    end
    if (st_ready !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL beatTimeout: got st_ready=%b want 1", st_ready);
    end
    @(negedge clk_st);
    st_valid = 1'b0;
    st_sop   = 1'b0;
    st_eop   = 1'b0;
  endtask

  task automatic sendPacket(input logic [7:0] base, input int n, input bit s,
                            input bit e);
    for (int i = 0; i < n; i++) begin
      applyStimulus(base + 8'(i), s && (i == 0), e && (i == n - 1));
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk_st);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drainTimeout: got %0d words left want 0", exp_q.size());
    end
    repeat (2) @(negedge clk_st);
  endtask

  // Monitor: every strobed word must be expected and must match.
  always @(negedge clk_st) begin
    if (rst_n === 1'b1 && bus_en === 1'b1) begin
      checkOutput("enWhileReady", BUS'(bus_ready), BUS'(1));
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedWord: got %h want none", bus_data);
      end else begin
        checkOutput($sformatf("word%0d", popped), bus_data, exp_q.pop_front());
        popped++;
      end
    end
  end

  initial begin
    int p0;
    rst_n     = 1'b0;
    bus_ready = 1'b1;
    st_valid  = 1'b0;
    st_sop    = 1'b0;
    st_eop    = 1'b0;
    st_data   = '0;
    repeat (3) @(negedge clk_st);
    checkOutput("rstBusEn", BUS'(bus_en), BUS'(0));
    checkOutput("rstBusData", bus_data, '0);
    checkOutput("rstReady", BUS'(st_ready), BUS'(0));
    @(posedge clk_st);
    #2 rst_n = 1'b1;
    #1 checkOutput("readyBeforeEdge", BUS'(st_ready), BUS'(0));
    @(posedge clk_st);
    #1 checkOutput("readyAfterEdge", BUS'(st_ready), BUS'(1));
    @(negedge clk_st);

    // 128-byte packet -> two full words.
    pushExp(8'h00, 63, 1, 0, 0, 12'd0);
    pushExp(8'h40, 63, 0, 1, 0, 12'd0);
    sendPacket(8'h00, 128, 1, 1);
    waitDrain();

    // 70-byte packet -> full word then a 6-byte word.
    pushExp(8'h10, 63, 1, 0, 0, 12'd1);
    pushExp(8'h50, 5, 0, 1, 0, 12'd1);
    sendPacket(8'h10, 70, 1, 1);
    waitDrain();

    // Single-byte packet.
    pushExp(8'hA5, 0, 1, 1, 0, 12'd2);
    sendPacket(8'hA5, 1, 1, 1);
    waitDrain();

    // Downstream stalled across a 128-byte packet.
    @(posedge clk_st);
    #1 bus_ready = 1'b0;
    @(negedge clk_st);
    pushExp(8'h20, 63, 1, 0, 0, 12'd3);
    pushExp(8'h60, 63, 0, 1, 0, 12'd3);
    p0 = popped;
    sendPacket(8'h20, 128, 1, 1);
    repeat (80) @(negedge clk_st);
    checkOutput("readyInHold", BUS'(st_ready), BUS'(0));
    checkOutput("noEnDuringStall", BUS'(popped), BUS'(p0));
    checkOutput("heldWords", BUS'(exp_q.size()), BUS'(2));
    @(posedge clk_st);
    #1 bus_ready = 1'b1;
    @(negedge clk_st);
    waitDrain();

    // sop at byte 30 restarts the packet.
    pushExp(8'h40, 29, 1, 1, 1, 12'd4);
    pushExp(8'h80, 3, 1, 1, 0, 12'd5);
    sendPacket(8'h40, 30, 1, 0);
    sendPacket(8'h80, 4, 1, 1);
    waitDrain();

    // sop&eop in the middle of a packet.
    pushExp(8'h90, 4, 1, 1, 1, 12'd6);
    pushExp(8'hC0, 0, 1, 1, 0, 12'd7);
    sendPacket(8'h90, 5, 1, 0);
    applyStimulus(8'hC0, 1, 1);
    waitDrain();

    // Beats without sop in IDLE are dropped and flag the next word.
    applyStimulus(8'h77, 0, 0);
    applyStimulus(8'h78, 0, 0);
    pushExp(8'h11, 2, 1, 1, 1, 12'd8);
    sendPacket(8'h11, 3, 1, 1);
    pushExp(8'h22, 1, 1, 1, 0, 12'd9);
    sendPacket(8'h22, 2, 1, 1);
    waitDrain();

    // Sequence number wraps from 4095 to 0.
    for (int i = 10; i <= 4096; i++) begin
      pushExp(8'(i), 0, 1, 1, 0, 12'(i));
      sendPacket(8'(i), 1, 1, 1);
    end
    waitDrain();

    // Reset in the middle of a packet.
    sendPacket(8'h50, 40, 1, 0);
    @(posedge clk_st);
    #2 rst_n = 1'b0;
    #1 checkOutput("midRstBusEn", BUS'(bus_en), BUS'(0));
    checkOutput("midRstBusData", bus_data, '0);
    checkOutput("midRstReady", BUS'(st_ready), BUS'(0));
    repeat (3) @(negedge clk_st);
    @(posedge clk_st);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk_st);
    pushExp(8'h33, 2, 1, 1, 0, 12'd0);
    sendPacket(8'h33, 3, 1, 1);
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
